// File: rtl/tinydec_pkg.sv
// Shared types and widths for the tinydec byte-stream front end.
package tinydec_pkg;

  localparam int unsigned BLK_W         = 32;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BYTES_PER_BLK = BLK_W / BYTE_W;

  // Issue-path FSM states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    HOLD
  } fsm_e;

endpackage

// File: rtl/tinydec_pack.sv
// Byte-to-word packer: big-endian assembly of up to four bytes into one block,
// with PAD fill for a block closed early by the last-of-frame flag.
module tinydec_pack
  import tinydec_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  input  logic              i_consume,
  output logic [BLK_W-1:0]  o_word,
  output logic              o_full,
  output logic              o_last
);

  logic [1:0]       r_idx;
  logic [1:0]       w_idx_d;
  logic [BLK_W-1:0] r_word;
  logic [BLK_W-1:0] w_word_d;
  logic             r_full;
  logic             w_full_d;
  logic             r_last;
  logic             w_last_d;
  logic             w_accept;
  logic             w_close;

  assign w_accept = i_valid & ~r_full;
  assign w_close  = w_accept & (i_last | (r_idx == 2'd3));

  always_comb begin
    w_idx_d  = r_idx;
    w_word_d = r_word;
    w_full_d = r_full;
    w_last_d = r_last;

    if (i_consume) begin
      w_full_d = 1'b0;
    end

    if (w_accept) begin
      // The first byte pre-fills the low bytes with PAD; later bytes overwrite them.
      unique case (r_idx)
        2'd0: w_word_d = {i_data, PAD, PAD, PAD};
        2'd1: w_word_d[23:16] = i_data;
        2'd2: w_word_d[15:8]  = i_data;
        2'd3: w_word_d[7:0]   = i_data;
        default: w_word_d = r_word;
      endcase

      if (w_close) begin
        w_idx_d  = 2'd0;
        w_full_d = 1'b1;
        w_last_d = i_last;
      end else begin
        w_idx_d = r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx  <= 2'd0;
      r_word <= '0;
      r_full <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_idx  <= w_idx_d;
      r_word <= w_word_d;
      r_full <= w_full_d;
      r_last <= w_last_d;
    end
  end

  assign o_ready = ~r_full;
  assign o_word  = r_word;
  assign o_full  = r_full;
  assign o_last  = r_last;

endmodule

// File: rtl/tinydec_stream.sv
// Byte-stream front end for tinydec: packs bytes into blocks, drives the decryptor
// req/ack handshake one block at a time and presents each result on m_* with a frame flag.
module tinydec_stream
  import tinydec_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD   = 8'h00,
  parameter int unsigned       CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              dec_req,
  output logic [BLK_W-1:0]  dec_wdata,
  input  logic              dec_ack,
  input  logic [BLK_W-1:0]  dec_rdata,
  output logic [BLK_W-1:0]  m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  blk_cnt
);

  logic [BLK_W-1:0] w_word;
  logic             w_full;
  logic             w_word_last;
  logic             w_consume;

  tinydec_pack #(
    .PAD (PAD)
  ) u_pack (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_data    (s_data),
    .i_valid   (s_valid),
    .i_last    (s_last),
    .o_ready   (s_ready),
    .i_consume (w_consume),
    .o_word    (w_word),
    .o_full    (w_full),
    .o_last    (w_word_last)
  );

  fsm_e             r_state;
  fsm_e             w_state_d;
  logic             r_req;
  logic             w_req_d;
  logic [BLK_W-1:0] r_wdata;
  logic [BLK_W-1:0] w_wdata_d;
  logic             r_blk_last;
  logic             w_blk_last_d;
  logic [BLK_W-1:0] r_mdata;
  logic [BLK_W-1:0] w_mdata_d;
  logic             r_mvalid;
  logic             w_mvalid_d;
  logic             r_mlast;
  logic             w_mlast_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  always_comb begin
    w_state_d    = r_state;
    w_req_d      = r_req;
    w_wdata_d    = r_wdata;
    w_blk_last_d = r_blk_last;
    w_mdata_d    = r_mdata;
    w_mvalid_d   = r_mvalid;
    w_mlast_d    = r_mlast;
    w_cnt_d      = r_cnt;
    w_consume    = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Waiting for ack high also rides out a decryptor still busy from before a reset.
        if (w_full && dec_ack) begin
          w_wdata_d    = w_word;
          w_blk_last_d = w_word_last;
          w_req_d      = 1'b1;
          w_consume    = 1'b1;
          w_state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Request is only known to be taken once ack drops; a stalled tinydec ignores it.
        if (!dec_ack) begin
          w_req_d   = 1'b0;
          w_state_d = BUSY;
        end
      end
      BUSY: begin
        if (dec_ack) begin
          w_mdata_d  = dec_rdata;
          w_mlast_d  = r_blk_last;
          w_mvalid_d = 1'b1;
          w_state_d  = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          w_mvalid_d = 1'b0;
          w_cnt_d    = r_cnt + CNT_W'(1);
          w_state_d  = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_wdata    <= '0;
      r_blk_last <= 1'b0;
      r_mdata    <= '0;
      r_mvalid   <= 1'b0;
      r_mlast    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_req      <= w_req_d;
      r_wdata    <= w_wdata_d;
      r_blk_last <= w_blk_last_d;
      r_mdata    <= w_mdata_d;
      r_mvalid   <= w_mvalid_d;
      r_mlast    <= w_mlast_d;
      r_cnt      <= w_cnt_d;
    end
  end

  assign dec_req   = r_req;
  assign dec_wdata = r_wdata;
  assign m_data    = r_mdata;
  assign m_valid   = r_mvalid;
  assign m_last    = r_mlast;
  assign blk_cnt   = r_cnt;

endmodule

// File: tb/tb_tinydec_stream.sv
// Bench for tinydec_stream: a behavioural tinydec responder, a byte-level packing model
// feeding expected queues, and a negedge monitor that scores every handshake.
module tb_tinydec_stream;
  import tinydec_pkg::*;

  localparam logic [7:0]  PAD   = 8'h00;
  localparam int unsigned CNT_W = 2;
  localparam int          ROUND = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             dec_req;
  logic [31:0]      dec_wdata;
  logic             dec_ack   = 1'b1;
  logic [31:0]      dec_rdata = '0;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic [CNT_W-1:0] blk_cnt;

  tinydec_stream #(
    .PAD   (PAD),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .dec_req   (dec_req),
    .dec_wdata (dec_wdata),
    .dec_ack   (dec_ack),
    .dec_rdata (dec_rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, want event (t=%0t)", name, $time);
  endtask

  // Behavioural tinydec stand-in: ack high when idle, stalls ignore req, fixed latency.
  logic        stall;
  logic        td_busy = 1'b0;
  int          td_cnt  = 0;
  int          td_lat  = ROUND;
  logic [31:0] td_word = '0;

  function automatic logic [31:0] td_f(input logic [31:0] x);
    return {x[7:0], x[31:8]} ^ 32'hC3A5_0F96;
  endfunction

  always @(posedge clk) begin
    if (td_busy) begin
      if (td_cnt <= 0) begin
        td_busy   <= 1'b0;
        dec_ack   <= 1'b1;
        dec_rdata <= td_f(td_word);
      end else begin
        td_cnt <= td_cnt - 1;
      end
    end else if (dec_req === 1'b1 && !stall) begin
      td_busy <= 1'b1;
      dec_ack <= 1'b0;
      td_word <= dec_wdata;
      td_cnt  <= td_lat - 1;
    end
  end

  // Consumer ready and tinydec stall drivers.
  bit hold_ready  = 1'b0;
  bit rand_en     = 1'b0;
  bit stall_force = 1'b0;

  initial begin
    m_ready = 1'b1;
    stall   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = hold_ready ? 1'b0 : (rand_en ? ($urandom_range(0, 3) != 0) : 1'b1);
      stall   = stall_force | (rand_en && $urandom_range(0, 3) == 0);
    end
  end

  // Reference model state and expected queues.
  logic [7:0]  pend[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_r[$];
  bit          exp_l[$];
  int unsigned exp_cnt = 0;

  bit          rst_p    = 1'b1;
  logic        req_p    = 1'b0;
  logic        ack_p    = 1'b1;
  logic        mv_p     = 1'b0;
  logic        mr_p     = 1'b1;
  logic [31:0] md_p     = '0;
  bit          chk_mv   = 1'b0;
  bit          inflight = 1'b0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (rst) begin
      pend.delete();
      exp_w.delete();
      exp_r.delete();
      exp_l.delete();
      exp_cnt  = 0;
      inflight = 1'b0;
      chk_mv   = 1'b0;
    end else if (!rst_p) begin
      if (req_p && !dec_req) check_eq("req_drop_before_ack", 32'(ack_p), 32'd0);
      if (!req_p && dec_req) begin
        check_eq("req_rise_ack", 32'(ack_p), 32'd1);
        check_eq("req_rise_mvalid", 32'(m_valid), 32'd0);
      end
      if (m_valid && !mv_p) check_eq("m_valid_rise_timing", 32'(chk_mv), 32'd1);
      else if (chk_mv) check_eq("m_valid_latency", 32'(m_valid), 32'd1);
      chk_mv = 1'b0;
      if (!ack_p && dec_ack && inflight) begin
        chk_mv   = 1'b1;
        inflight = 1'b0;
      end
      if (mv_p && !mr_p) begin
        check_eq("m_valid_held", 32'(m_valid), 32'd1);
        check_eq("m_data_stable", m_data, md_p);
      end

      if (dec_req && dec_ack && !stall && !td_busy) begin
        if (exp_w.size() == 0) fail_now("unexpected_req");
        else check_eq("dec_wdata", dec_wdata, exp_w.pop_front());
        inflight = 1'b1;
      end

      if (m_valid && m_ready) begin
        if (exp_r.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          check_eq("m_data", m_data, exp_r.pop_front());
          check_eq("m_last", 32'(m_last), 32'(exp_l.pop_front()));
        end
        check_eq("blk_cnt_at_handshake", 32'(blk_cnt), exp_cnt % (1 << CNT_W));
        exp_cnt++;
      end

      if (s_valid && s_ready) begin
        pend.push_back(s_data);
        if (pend.size() == 4 || s_last) begin
          w = '0;
          for (int i = 0; i < 4; i++) w = {w[23:0], (i < pend.size()) ? pend[i] : PAD};
          exp_w.push_back(w);
          exp_r.push_back(td_f(w));
          exp_l.push_back(s_last);
          pend.delete();
        end
      end
    end
    rst_p = rst;
    req_p = dec_req;
    ack_p = dec_ack;
    mv_p  = m_valid;
    mr_p  = m_ready;
    md_p  = m_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 400) begin
        fail_now("s_ready_timeout");
        break;
      end
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_w.size() == 0 && exp_r.size() == 0 && pend.size() == 0 && !m_valid && dec_ack)
        break;
      n++;
      if (n > 2000) begin
        fail_now("drain_timeout");
        break;
      end
    end
    step();
  endtask

  initial begin
    logic [31:0] md;
    int          n;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd1);
    check_eq("rst_dec_req", 32'(dec_req), 32'd0);
    check_eq("rst_dec_wdata", dec_wdata, 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_data", m_data, 32'd0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    step();

    // Full block, request one cycle after the closing byte.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t1_req_latency", 32'(dec_req), 32'd1);
    check_eq("t1_wdata", dec_wdata, 32'h1122_3344);
    wait_drain();
    check_eq("t1_blk_cnt", 32'(blk_cnt), 32'd1);

    // Partial block closed by s_last.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t2_req", 32'(dec_req), 32'd1);
    check_eq("t2_wdata_pad", dec_wdata, 32'hAABB_0000);
    wait_drain();
    check_eq("t2_blk_cnt", 32'(blk_cnt), 32'd2);

    // Stalled tinydec: req must stay up until ack falls.
    stall_force = 1'b1;
    send_byte(8'h5A, 1'b0);
    send_byte(8'h6B, 1'b0);
    send_byte(8'h7C, 1'b0);
    send_byte(8'h8D, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_req_held", 32'(dec_req), 32'd1);
      check_eq("t3_ack_high", 32'(dec_ack), 32'd1);
    end
    step();
    stall_force = 1'b0;
    wait_drain();
    check_eq("t3_blk_cnt", 32'(blk_cnt), 32'd3);

    // Back-pressure: one result held, next block buffered, input stalls.
    hold_ready = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      if (m_valid) break;
      n++;
      if (n > 100) begin
        fail_now("t4_m_valid_timeout");
        break;
      end
    end
    md = m_data;
    step();
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h08, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("t4_s_ready_low", 32'(s_ready), 32'd0);
      check_eq("t4_no_req", 32'(dec_req), 32'd0);
      check_eq("t4_m_data_stable", m_data, md);
    end
    step();
    hold_ready = 1'b0;
    wait_drain();
    check_eq("t4_blk_cnt_wrap", 32'(blk_cnt), 32'd1);

    // Reset while BUSY; the next block must wait for tinydec to finish.
    td_lat = 16;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      if (!dec_ack) break;
      n++;
      if (n > 100) begin
        fail_now("t5_ack_low_timeout");
        break;
      end
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_m_valid", 32'(m_valid), 32'd0);
    check_eq("t5_blk_cnt", 32'(blk_cnt), 32'd0);
    check_eq("t5_dec_req", 32'(dec_req), 32'd0);
    check_eq("t5_s_ready", 32'(s_ready), 32'd1);
    step();
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'hD4, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      if (dec_ack) break;
      check_eq("t5_wait_ack", 32'(dec_req), 32'd0);
      n++;
      if (n > 100) begin
        fail_now("t5_ack_high_timeout");
        break;
      end
    end
    step();
    wait_drain();
    check_eq("t5_blk_cnt_after", 32'(blk_cnt), 32'd1);
    td_lat = ROUND;

    // Randomized traffic with random stalls and back-pressure.
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'($urandom), (i == 299) || ($urandom_range(0, 4) == 0));
      repeat ($urandom_range(0, 2)) step();
    end
    rand_en = 1'b0;
    wait_drain();
    check_eq("rand_blk_cnt_final", 32'(blk_cnt), exp_cnt % (1 << CNT_W));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got still running, want finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

endmodule
